// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: PHT of saturating counters, direct-mapped BTB
// and a non-speculative global history register, with saturating statistics.
module branch_predictor_gshare #(
  parameter int PC_WIDTH       = 32,
  parameter int INSTR_ALIGN    = 2,
  parameter int PHT_INDEX_BITS = 8,
  parameter int BHR_WIDTH      = 8,
  parameter int CTR_WIDTH      = 2,
  parameter int BTB_INDEX_BITS = 4,
  parameter int MODE           = 1,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_target,
  output logic                  pred_btb_hit,
  output logic [BHR_WIDTH-1:0]  pred_bhr,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic [BHR_WIDTH-1:0]  upd_bhr,
  input  logic                  upd_mispredict,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  // Handshake: lookup_valid and upd_valid are valid-only qualifiers with no ready;
  // one lookup and one update are accepted every cycle, the update on the rising edge.

  localparam int PHT_DEPTH = 1 << PHT_INDEX_BITS;
  localparam int BTB_DEPTH = 1 << BTB_INDEX_BITS;
  localparam int TAG_WIDTH = PC_WIDTH - INSTR_ALIGN - BTB_INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [PC_WIDTH-1:0]  PC_STEP  = PC_WIDTH'(1) << INSTR_ALIGN;

  logic [CTR_WIDTH-1:0] pht_q [PHT_DEPTH];
  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAG_WIDTH-1:0] btb_tag_q [BTB_DEPTH];
  logic [PC_WIDTH-1:0]  btb_target_q [BTB_DEPTH];
  logic [BHR_WIDTH-1:0] bhr_q;

  function automatic logic [PHT_INDEX_BITS-1:0] pht_index(
    input logic [PC_WIDTH-1:0]  pc,
    input logic [BHR_WIDTH-1:0] hist
  );
    logic [PHT_INDEX_BITS-1:0] hist_ext;
    hist_ext = '0;
    hist_ext[BHR_WIDTH-1:0] = hist;
    if (MODE == 0) return pc[INSTR_ALIGN +: PHT_INDEX_BITS];
    return pc[INSTR_ALIGN +: PHT_INDEX_BITS] ^ hist_ext;
  endfunction

  // Lookup side: purely combinational from current state, no bypass of same-cycle updates.
  logic [PHT_INDEX_BITS-1:0] lk_pht_idx;
  logic [BTB_INDEX_BITS-1:0] lk_btb_idx;
  logic [TAG_WIDTH-1:0]      lk_tag;
  logic [CTR_WIDTH-1:0]      lk_ctr;

  always_comb begin
    lk_pht_idx   = pht_index(lookup_pc, bhr_q);
    lk_btb_idx   = lookup_pc[INSTR_ALIGN +: BTB_INDEX_BITS];
    lk_tag       = lookup_pc[PC_WIDTH-1 -: TAG_WIDTH];
    lk_ctr       = pht_q[lk_pht_idx];
    pred_btb_hit = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    pred_taken   = pred_btb_hit && lk_ctr[CTR_WIDTH-1];
    pred_target  = pred_taken ? btb_target_q[lk_btb_idx] : lookup_pc + PC_STEP;
    pred_bhr     = bhr_q;
  end

  // Update side indexes with the returned snapshot, not the live history.
  logic [PHT_INDEX_BITS-1:0] up_pht_idx;
  logic [BTB_INDEX_BITS-1:0] up_btb_idx;
  logic [TAG_WIDTH-1:0]      up_tag;
  logic [BHR_WIDTH:0]        bhr_shift;
  logic                      upd_pc_unused;

  always_comb begin
    up_pht_idx    = pht_index(upd_pc, upd_bhr);
    up_btb_idx    = upd_pc[INSTR_ALIGN +: BTB_INDEX_BITS];
    up_tag        = upd_pc[PC_WIDTH-1 -: TAG_WIDTH];
    bhr_shift     = {bhr_q, upd_taken};
    upd_pc_unused = &{1'b0, upd_pc[INSTR_ALIGN-1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CTR_INIT;
      btb_valid_q <= '0;
      bhr_q       <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (pht_q[up_pht_idx] != '1) pht_q[up_pht_idx] <= pht_q[up_pht_idx] + CTR_WIDTH'(1);
        btb_valid_q[up_btb_idx] <= 1'b1;
      end else if (pht_q[up_pht_idx] != '0) begin
        pht_q[up_pht_idx] <= pht_q[up_pht_idx] - CTR_WIDTH'(1);
      end
      bhr_q <= bhr_shift[BHR_WIDTH-1:0];
    end
  end

  // Tag/target payload needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag_q[up_btb_idx]    <= up_tag;
      btb_target_q[up_btb_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_valid && (stat_lookups != '1))
        stat_lookups <= stat_lookups + STAT_WIDTH'(1);
      if (upd_valid && upd_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: a bimodal instance (4-bit stats) and a gshare instance share stimulus.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [3:0]  upd_bhr = '0;
  logic        mis_b = 1'b0;
  logic        mis_g = 1'b0;

  logic        b_taken, g_taken, b_hit, g_hit;
  logic [31:0] b_target, g_target;
  logic [3:0]  b_bhr, g_bhr;
  logic [3:0]  b_lookups, b_mispred;
  logic [15:0] g_lookups, g_mispred;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.BHR_WIDTH(4), .MODE(0), .STAT_WIDTH(4)) u_bim (
    .clk(clk), .reset_n(reset_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(b_taken), .pred_target(b_target), .pred_btb_hit(b_hit), .pred_bhr(b_bhr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_bhr(upd_bhr), .upd_mispredict(mis_b),
    .stat_lookups(b_lookups), .stat_mispredicts(b_mispred)
  );

  branch_predictor_gshare #(.BHR_WIDTH(4), .MODE(1), .STAT_WIDTH(16)) u_gsh (
    .clk(clk), .reset_n(reset_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(g_taken), .pred_target(g_target), .pred_btb_hit(g_hit), .pred_bhr(g_bhr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_bhr(upd_bhr), .upd_mispredict(mis_g),
    .stat_lookups(g_lookups), .stat_mispredicts(g_mispred)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1 with the update applied.
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int  b_miss, g_miss;
    logic tk;

    // Reset values, held in reset then after release
    lookup_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_taken", {31'b0, b_taken}, 32'd0);
    check("rst_hit", {31'b0, b_hit}, 32'd0);
    check("rst_target", b_target, 32'h104);
    check("rst_bhr", {28'b0, g_bhr}, 32'd0);
    check("rst_lookups", {28'b0, b_lookups}, 32'd0);
    check("rst_mispred", {16'b0, g_mispred}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_taken", {31'b0, g_taken}, 32'd0);
    check("post_rst_target", g_target, 32'h104);
    check("post_rst_hit", {31'b0, g_hit}, 32'd0);

    // Bimodal training
    upd(32'h200, 1'b1, 32'h380);
    upd(32'h200, 1'b1, 32'h380);
    look(32'h200);
    check("bim_hit", {31'b0, b_hit}, 32'd1);
    check("bim_taken", {31'b0, b_taken}, 32'd1);
    check("bim_target", b_target, 32'h380);
    repeat (3) upd(32'h200, 1'b0, 32'h0);
    look(32'h200);
    check("bim_nt_taken", {31'b0, b_taken}, 32'd0);
    check("bim_nt_target", b_target, 32'h204);
    check("bim_nt_hit", {31'b0, b_hit}, 32'd1);
    repeat (5) upd(32'h200, 1'b0, 32'h0);
    upd(32'h200, 1'b1, 32'h380);
    look(32'h200);
    check("bim_sat0_one_t", {31'b0, b_taken}, 32'd0);
    upd(32'h200, 1'b1, 32'h380);
    look(32'h200);
    check("bim_sat0_two_t", {31'b0, b_taken}, 32'd1);

    // Same-cycle lookup/update conflict from counter 01
    do_reset();
    lookup_pc  = 32'h200;
    upd_valid  = 1'b1;
    upd_pc     = 32'h200;
    upd_taken  = 1'b1;
    upd_target = 32'h380;
    #1;
    check("conf_same_taken", {31'b0, b_taken}, 32'd0);
    check("conf_same_target", b_target, 32'h204);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    check("conf_next_taken", {31'b0, b_taken}, 32'd1);
    check("conf_next_target", b_target, 32'h380);

    // BTB aliasing: 0x040 and 0x440 share BTB entry 0
    upd(32'h040, 1'b1, 32'h800);
    upd(32'h440, 1'b1, 32'h900);
    look(32'h040);
    check("alias_old_hit", {31'b0, b_hit}, 32'd0);
    check("alias_old_target", b_target, 32'h044);
    look(32'h440);
    check("alias_new_hit", {31'b0, b_hit}, 32'd1);
    check("alias_new_target", b_target, 32'h900);

    // Alternating T/NT branch at 0x400
    do_reset();
    b_miss = 0;
    g_miss = 0;
    lookup_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tk = (i % 2 == 0);
      look(32'h400);
      mis_b   = (b_taken != tk);
      mis_g   = (g_taken != tk);
      upd_bhr = g_bhr;
      if (i >= 24) begin
        if (mis_b) b_miss++;
        if (mis_g) g_miss++;
      end
      upd(32'h400, tk, 32'h600);
      mis_b = 1'b0;
      mis_g = 1'b0;
    end
    lookup_valid = 1'b0;
    upd_bhr = '0;
    check("alt_gsh_last8_miss", g_miss, 32'd0);
    check("alt_bim_last8_ge4", {31'b0, (b_miss >= 4)}, 32'd1);
    check("alt_gsh_bhr", {28'b0, g_bhr}, 32'hA);
    check("alt_bim_mispred_sat", {28'b0, b_mispred}, 32'd15);
    check("alt_gsh_lookups", {16'b0, g_lookups}, 32'd32);

    // Stats saturation and asynchronous clear
    do_reset();
    lookup_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    check("stat_lk_sat", {28'b0, b_lookups}, 32'd15);
    check("stat_lk_wide", {16'b0, g_lookups}, 32'd20);
    mis_b = 1'b1;
    repeat (3) upd(32'h0, 1'b0, 32'h0);
    mis_b = 1'b0;
    check("stat_mis3", {28'b0, b_mispred}, 32'd3);
    check("stat_mis_gsh0", {16'b0, g_mispred}, 32'd0);
    check("stat_lk_hold", {28'b0, b_lookups}, 32'd15);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_lk_clr", {28'b0, b_lookups}, 32'd0);
    check("async_mis_clr", {28'b0, b_mispred}, 32'd0);
    check("async_gsh_lk_clr", {16'b0, g_lookups}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
